// File: rtl/eth_axis_frame_filter_pkg.sv
// Shared definitions for the Ethernet AXI-Stream frame filter.
// Register map indices, ID constant, FSM state type, saturating increment.
package pkg_eth_frame_filter;

    localparam logic [7:0] REG_ID        = 8'd0;
    localparam logic [7:0] REG_CTRL      = 8'd1;
    localparam logic [7:0] REG_ETHERTYPE = 8'd2;
    localparam logic [7:0] REG_ACCEPTED  = 8'd3;
    localparam logic [7:0] REG_DROPPED   = 8'd4;
    localparam logic [7:0] REG_BADFCS    = 8'd5;
    localparam logic [7:0] REG_MAC_LO    = 8'd6;
    localparam logic [7:0] REG_MAC_HI    = 8'd7;

    localparam logic [31:0] ID_VALUE = 32'h4646_0001;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/eth_axis_frame_filter_if.sv
// AXI-Stream bundle used on both sides of the frame filter.
// master drives payload and valid, slave drives ready.
interface eth_axis_frame_filter_if #(
    parameter int DW = 128
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/eth_axis_frame_filter_regs.sv
// Wishbone register file: config, saturating frame counters, clear.
// FRAME_FILTER_DST_MAC_EN adds MAC_LO/MAC_HI and CTRL.mac_match.
module eth_frame_filter_regs
    import pkg_eth_frame_filter::*;
#(
    parameter logic [15:0] DEFAULT_ETHERTYPE = 16'h0000,
    parameter logic        DEFAULT_ENABLE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    input  logic        inc_acc,
    input  logic        inc_drop,
    input  logic        inc_bad,
`ifdef FRAME_FILTER_DST_MAC_EN
    output logic        mac_match,
    output logic [47:0] mac,
`endif
    output logic        enable,
    output logic [15:0] ethertype
);

    logic [31:0] cnt_acc;
    logic [31:0] cnt_drop;
    logic [31:0] cnt_bad;
    logic [31:0] rdata;
    logic        req;
    logic        wr;
    logic        clr;

    assign req = wb_cyc && wb_stb && !wb_ack;
    assign wr  = req && wb_we;
    assign clr = wr && (wb_adr == REG_CTRL) && wb_dat_i[1];

`ifndef FRAME_FILTER_DST_MAC_EN
    logic unused_dat;
    assign unused_dat = ^wb_dat_i[31:16];
`endif

    always_comb begin
        rdata = '0;
        unique case (wb_adr)
            REG_ID:        rdata = ID_VALUE;
            REG_CTRL: begin
                rdata[0] = enable;
`ifdef FRAME_FILTER_DST_MAC_EN
                rdata[2] = mac_match;
`endif
            end
            REG_ETHERTYPE: rdata[15:0] = ethertype;
            REG_ACCEPTED:  rdata = cnt_acc;
            REG_DROPPED:   rdata = cnt_drop;
            REG_BADFCS:    rdata = cnt_bad;
`ifdef FRAME_FILTER_DST_MAC_EN
            REG_MAC_LO:    rdata = mac[31:0];
            REG_MAC_HI:    rdata[15:0] = mac[47:32];
`endif
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack    <= 1'b0;
            wb_dat_o  <= '0;
            enable    <= DEFAULT_ENABLE;
            ethertype <= DEFAULT_ETHERTYPE;
            cnt_acc   <= '0;
            cnt_drop  <= '0;
            cnt_bad   <= '0;
`ifdef FRAME_FILTER_DST_MAC_EN
            mac_match <= 1'b0;
            mac       <= '0;
`endif
        end else begin
            wb_ack   <= req;
            wb_dat_o <= (req && !wb_we) ? rdata : '0;
            if (wr) begin
                unique case (wb_adr)
                    REG_CTRL: begin
                        enable <= wb_dat_i[0];
`ifdef FRAME_FILTER_DST_MAC_EN
                        mac_match <= wb_dat_i[2];
`endif
                    end
                    REG_ETHERTYPE: ethertype <= wb_dat_i[15:0];
`ifdef FRAME_FILTER_DST_MAC_EN
                    REG_MAC_LO: mac[31:0]  <= wb_dat_i;
                    REG_MAC_HI: mac[47:32] <= wb_dat_i[15:0];
`endif
                    default: ;
                endcase
            end
            // a clear landing on the same edge as an increment wins
            if (clr) begin
                cnt_acc  <= '0;
                cnt_drop <= '0;
                cnt_bad  <= '0;
            end else begin
                if (inc_acc)  cnt_acc  <= sat_inc(cnt_acc);
                if (inc_drop) cnt_drop <= sat_inc(cnt_drop);
                if (inc_bad)  cnt_bad  <= sat_inc(cnt_bad);
            end
        end
    end

endmodule

// File: rtl/eth_axis_frame_filter.sv
// Per-frame forward/drop filter on EtherType, one registered output stage.
// FRAME_FILTER_DST_MAC_EN adds destination MAC matching.
module eth_axis_frame_filter
    import pkg_eth_frame_filter::*;
#(
    parameter int          DATA_WIDTH        = 128,
    parameter logic [15:0] DEFAULT_ETHERTYPE = 16'h0000,
    parameter logic        DEFAULT_ENABLE    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    eth_axis_frame_filter_if.slave  s_axis,
    eth_axis_frame_filter_if.master m_axis,
    input  logic [7:0]              wb_adr,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic                    wb_we,
    input  logic                    wb_stb,
    input  logic                    wb_cyc,
    output logic                    wb_ack
);

    if (DATA_WIDTH != 128) begin : g_width_check
        $error("eth_axis_frame_filter supports DATA_WIDTH=128 only");
    end

    state_t      state;
    logic        enable;
    logic [15:0] ethertype;
    logic [15:0] et;
    logic        runt;
    logic        mac_ok;
    logic        fwd_new;
    logic        fire;
    logic        fwd_beat;
    logic        drop_beat;
    logic        inc_acc;
    logic        inc_drop;
    logic        inc_bad;

    assign s_axis.tready = (state == DROP) || !m_axis.tvalid || m_axis.tready;

    assign fire = s_axis.tvalid && s_axis.tready;
    assign et   = {s_axis.tdata[103:96], s_axis.tdata[111:104]};
    assign runt = s_axis.tkeep[13:0] != 14'h3FFF;

`ifdef FRAME_FILTER_DST_MAC_EN
    logic        mac_match;
    logic [47:0] mac;
    logic [47:0] dst;

    assign dst = {s_axis.tdata[7:0],   s_axis.tdata[15:8],
                  s_axis.tdata[23:16], s_axis.tdata[31:24],
                  s_axis.tdata[39:32], s_axis.tdata[47:40]};
    assign mac_ok = !mac_match || (dst == mac) || (&dst);
`else
    assign mac_ok = 1'b1;
`endif

    // config is only looked at on the first beat, so it is frozen per frame
    assign fwd_new   = !enable || (!runt && (et == ethertype) && mac_ok);
    assign fwd_beat  = fire && (((state == IDLE) && fwd_new) || (state == PASS));
    assign drop_beat = fire && (((state == IDLE) && !fwd_new) || (state == DROP));
    assign inc_acc   = fwd_beat && s_axis.tlast;
    assign inc_drop  = drop_beat && s_axis.tlast;
    assign inc_bad   = inc_acc && s_axis.tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tkeep  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else begin
            if (fwd_beat) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= s_axis.tdata;
                m_axis.tkeep  <= s_axis.tkeep;
                m_axis.tlast  <= s_axis.tlast;
                m_axis.tuser  <= s_axis.tuser;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            unique case (state)
                IDLE: if (fire && !s_axis.tlast)
                          state <= fwd_new ? PASS : DROP;
                PASS: if (fire && s_axis.tlast) state <= IDLE;
                DROP: if (fire && s_axis.tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    eth_frame_filter_regs #(
        .DEFAULT_ETHERTYPE (DEFAULT_ETHERTYPE),
        .DEFAULT_ENABLE    (DEFAULT_ENABLE)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .wb_adr    (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we     (wb_we),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .inc_acc   (inc_acc),
        .inc_drop  (inc_drop),
        .inc_bad   (inc_bad),
`ifdef FRAME_FILTER_DST_MAC_EN
        .mac_match (mac_match),
        .mac       (mac),
`endif
        .enable    (enable),
        .ethertype (ethertype)
    );

endmodule

// File: tb/tb_eth_axis_frame_filter.sv
// Scoreboard bench for eth_axis_frame_filter: random frames vs a frame-level model.
// Define FRAME_FILTER_DST_MAC_EN to also exercise destination MAC matching.
module tb_eth_axis_frame_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;

    always #5 clk = ~clk;

    eth_axis_frame_filter_if #(.DW(128)) s_if ();
    eth_axis_frame_filter_if #(.DW(128)) m_if ();

    eth_axis_frame_filter dut (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we    (wb_we),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    bp_en  = 0;

    // reference model state: configuration and frame counters
    bit          m_en  = 0;
    logic [15:0] m_et  = 16'h0000;
    bit          m_mm  = 0;
    logic [47:0] m_mac = 48'h0;
    int unsigned n_acc = 0, n_drp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: a transfer happens at the next posedge when valid&&ready now
    initial begin
        beat_t got, want;
        forever begin
            @(negedge clk);
            if (!rst && m_if.tvalid && m_if.tready) begin
                got = '{m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    chk("beat", 160'(got), 160'(want));
                end
            end
        end
    end

    task automatic wb_xfer(input logic [7:0] a, input logic [31:0] d,
                           input bit we, output logic [31:0] q);
        int n = 0;
        wb_adr = a; wb_dat_i = d; wb_we = we; wb_cyc = 1; wb_stb = 1;
        q = '0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_ack) begin
                q = wb_dat_o;
                break;
            end
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL wb_timeout: got no ack expected ack adr %0d", a);
                break;
            end
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(a, d, 1'b1, q);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a,
                          input logic [31:0] e);
        logic [31:0] q;
        wb_xfer(a, 32'h0, 1'b0, q);
        chk(nm, 160'(q), 160'(e));
    endtask

    task automatic push_beat(input beat_t b);
        int n = 0;
        bit ok;
        s_if.tdata = b.d; s_if.tkeep = b.k;
        s_if.tlast = b.l; s_if.tuser = b.u;
        s_if.tvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            ok = s_if.tready;
            @(posedge clk);
            #1;
            n++;
            if (ok) break;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got tready=0 expected tready=1");
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    function automatic logic [31:0] ctrl_word(input bit clr);
        return {29'b0, m_mm, clr, m_en};
    endfunction

    // mid_et >= 0 rewrites ETHERTYPE after the first beat; clr_last
    // writes CTRL.clear on the very edge that accepts the last beat
    task automatic send_frame(input int len, input logic [15:0] et,
                              input logic [47:0] dst, input bit user,
                              input int mid_et = -1, input bit clr_last = 0);
        byte unsigned fr[];
        beat_t b;
        bit fwd, runt, macok;
        int nb;
        fr = new[len];
        foreach (fr[i]) fr[i] = 8'($urandom);
        for (int i = 0; i < 6 && i < len; i++) fr[i] = dst[47-8*i -: 8];
        if (len > 13) begin
            fr[12] = et[15:8];
            fr[13] = et[7:0];
        end
        runt  = len < 14;
        macok = !m_mm || dst == m_mac || dst == 48'hFFFF_FFFF_FFFF;
        fwd   = !m_en || (!runt && et == m_et && macok);
        nb    = (len + 15) / 16;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int i = 0; i < 16; i++)
                if (bi * 16 + i < len) begin
                    b.d[8*i +: 8] = fr[bi*16+i];
                    b.k[i] = 1'b1;
                end
            b.l = (bi == nb - 1);
            b.u = b.l ? user : 1'b0;
            if (fwd) exp_q.push_back(b);
            if (b.l && clr_last) begin
                fork
                    push_beat(b);
                    wb_write(8'd1, ctrl_word(1'b1));
                join
            end else begin
                push_beat(b);
            end
            if (bi == 0 && mid_et >= 0) begin
                wb_write(8'd2, 32'(mid_et));
                m_et = 16'(mid_et);
            end
        end
        if (fwd) begin
            n_acc++;
            if (user) n_bad++;
        end else begin
            n_drp++;
        end
        if (clr_last) begin
            n_acc = 0; n_drp = 0; n_bad = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 160'(exp_q.size()), 160'(0));
    endtask

    task automatic chk_counters(input string tag);
        rd_chk({tag, "_accepted"}, 8'd3, n_acc);
        rd_chk({tag, "_dropped"},  8'd4, n_drp);
        rd_chk({tag, "_badfcs"},   8'd5, n_bad);
    endtask

    task automatic clear_all();
        wb_write(8'd1, ctrl_word(1'b1));
        n_acc = 0; n_drp = 0; n_bad = 0;
    endtask

    logic [15:0] ets[3];

    initial begin
        rst = 1; wb_adr = 0; wb_dat_i = 0; wb_we = 0; wb_stb = 0; wb_cyc = 0;
        s_if.tdata = 0; s_if.tkeep = 0; s_if.tvalid = 0;
        s_if.tlast = 0; s_if.tuser = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_tvalid", 160'(m_if.tvalid), 160'(0));
        chk("rst_tdata",  160'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}), 160'(0));
        chk("rst_ack",    160'({wb_ack, wb_dat_o}), 160'(0));
        @(posedge clk);
        #1;
        rd_chk("id", 8'd0, 32'h4646_0001);
        rd_chk("ctrl_rst", 8'd1, 32'h0);
        rd_chk("etype_rst", 8'd2, 32'h0);
        chk_counters("rst");
        rd_chk("unmapped", 8'd9, 32'h0);
`ifndef FRAME_FILTER_DST_MAC_EN
        rd_chk("mac_lo_absent", 8'd6, 32'h0);
        wb_write(8'd1, 32'h5);
        rd_chk("ctrl_bit2_absent", 8'd1, 32'h1);
        wb_write(8'd1, 32'h0);
`endif

        // disabled: everything passes
        bp_en = 1;
        send_frame(64, 16'h0800, 48'h1122_3344_5566, 0);
        send_frame(65, 16'h88B5, 48'h0A0B_0C0D_0E0F, 0);
        send_frame(1514, 16'h86DD, 48'hFFFF_FFFF_FFFF, 0);
        drain();
        chk_counters("pass_all");

        clear_all();
        rd_chk("ctrl_clr_rb", 8'd1, 32'h0);
        chk_counters("cleared");

        // enabled EtherType filter
        wb_write(8'd2, 32'h88B5); m_et = 16'h88B5;
        m_en = 1; wb_write(8'd1, ctrl_word(1'b0));
        rd_chk("etype_rb", 8'd2, 32'h88B5);
        send_frame(100, 16'h88B5, 48'h1, 0);
        send_frame(80,  16'h0800, 48'h1, 0);
        send_frame(47,  16'h88B5, 48'h1, 0);
        drain();
        chk_counters("filter");

        // runt single beat, then a good frame proves IDLE
        clear_all();
        send_frame(10, 16'h88B5, 48'h1, 0);
        drain();
        chk_counters("runt");
        send_frame(14, 16'h88B5, 48'h1, 0);
        drain();
        chk_counters("after_runt");

        // bad FCS under backpressure
        clear_all();
        send_frame(200, 16'h88B5, 48'h2, 1);
        send_frame(33, 16'h0800, 48'h2, 1);
        drain();
        chk_counters("badfcs");

        // random frames
        ets[0] = 16'h88B5; ets[1] = 16'h0800; ets[2] = 16'h88B6;
        for (int i = 0; i < 25; i++)
            send_frame($urandom_range(8, 300), ets[$urandom_range(0, 2)],
                       {$urandom, 16'($urandom)}, 1'($urandom_range(0, 1)));
        drain();
        chk_counters("random");

        // EtherType changes mid-frame: current frame keeps the old value
        clear_all();
        send_frame(80, 16'h88B5, 48'h3, 0, 32'h0800);
        send_frame(64, 16'h88B5, 48'h3, 0);
        send_frame(64, 16'h0800, 48'h3, 0);
        drain();
        chk_counters("mid_et");

        // clear on the same edge as the tlast increment
        bp_en = 0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        send_frame(30, 16'h0800, 48'h4, 1, -1, 1);
        drain();
        chk_counters("clr_vs_inc");

`ifdef FRAME_FILTER_DST_MAC_EN
        bp_en = 1;
        wb_write(8'd7, 32'h0000_0200);
        wb_write(8'd6, 32'h0000_0001);
        m_mac = 48'h0200_0000_0001;
        m_mm = 1; wb_write(8'd1, ctrl_word(1'b0));
        rd_chk("ctrl_mm", 8'd1, 32'h5);
        rd_chk("mac_hi", 8'd7, 32'h0200);
        clear_all();
        send_frame(64, 16'h0800, 48'h0200_0000_0001, 0);
        send_frame(64, 16'h0800, 48'hFFFF_FFFF_FFFF, 0);
        send_frame(64, 16'h0800, 48'h0200_0000_0002, 0);
        drain();
        chk_counters("mac");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
